// File: rtl/weight_fetch_ctrl.sv
// rtl/weight_fetch_ctrl.sv - weight SRAM read master streaming words through a 2-entry skid FIFO
//
// Purpose: fetches i_num_words sequential 80-bit weight words starting at
// i_base_addr from a 1-cycle-latency SRAM and presents them in address order
// on a valid/ready stream. A 2-entry FIFO absorbs the read latency so that
// consumer back-pressure never drops data and full-rate reads sustain one
// word per cycle.
//
// Ports:
//   i_clk, i_rst      clock, asynchronous active-high reset
//   i_start           request pulse (sampled only when idle)
//   i_base_addr       first word address, sampled with i_start
//   i_num_words       number of words, sampled with i_start
//   o_busy            job in progress (FETCH or DRAIN)
//   o_done            1-cycle pulse at job completion
//   o_err             1-cycle pulse when a request is rejected
//   o_sram_csb        SRAM chip select, active low (read issued this cycle)
//   o_sram_wsb        SRAM write strobe, active low, tied inactive
//   o_sram_raddr      SRAM read address
//   i_sram_rdata      SRAM read data, valid the cycle after a read issue
//   o_w_valid         output word valid
//   i_w_ready         consumer ready
//   o_w_data          output word (FIFO head)

module weight_fetch_ctrl #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 80,
  parameter int DEPTH  = 20250
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_base_addr,
  input  logic [ADDR_W-1:0] i_num_words,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err,
  output logic              o_sram_csb,
  output logic              o_sram_wsb,
  output logic [ADDR_W-1:0] o_sram_raddr,
  input  logic [DATA_W-1:0] i_sram_rdata,
  output logic              o_w_valid,
  input  logic              i_w_ready,
  output logic [DATA_W-1:0] o_w_data
);

  localparam int CW = ADDR_W + 1;
  localparam int SW = ADDR_W + 2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_DRAIN
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [ADDR_W-1:0] r_base;
  logic [ADDR_W-1:0] r_raddr;
  logic [CW-1:0]     r_count;
  logic [CW-1:0]     r_issued;
  logic [CW-1:0]     r_popped;
  logic              r_inflight;
  logic [DATA_W-1:0] r_fifo [2];
  logic              r_rd_ptr;
  logic              r_wr_ptr;
  logic [1:0]        r_occ;
  logic              r_done;
  logic              r_err;

  logic              w_pop;
  logic [2:0]        w_pending;
  logic              w_issue;
  logic [ADDR_W-1:0] w_issue_addr;
  logic [SW-1:0]     w_req_end;
  logic              w_req_err;
  logic              w_req_zero;
  logic              w_accept;
  logic [CW-1:0]     w_popped_nxt;
  logic              w_last_pop;

  assign o_w_valid = (r_occ != 2'd0);
  assign o_w_data  = r_fifo[r_rd_ptr];
  assign w_pop     = o_w_valid & i_w_ready;

  // Slots the FIFO will hold after this cycle's pop and the in-flight push;
  // a new read is only safe if at most one slot is committed.
  assign w_pending = {1'b0, r_occ} + {2'b00, r_inflight} - {2'b00, w_pop};

  assign w_issue      = (r_state == S_FETCH) && (r_issued < r_count) && (w_pending <= 3'd1);
  assign w_issue_addr = r_base + r_issued[ADDR_W-1:0];

  // Extra-wide sum so base+count past the top of the SRAM cannot wrap.
  assign w_req_end  = {2'b00, i_base_addr} + {2'b00, i_num_words};
  assign w_req_err  = (w_req_end > SW'(DEPTH));
  assign w_req_zero = (i_num_words == '0);
  assign w_accept   = (r_state == S_IDLE) && i_start && !w_req_err && !w_req_zero;

  // Completion is detected on the final pop so done and the return to IDLE
  // land on the same edge.
  assign w_popped_nxt = r_popped + CW'(w_pop);
  assign w_last_pop   = (r_state == S_DRAIN) && (w_popped_nxt == r_count);

  assign o_busy       = (r_state != S_IDLE);
  assign o_done       = r_done;
  assign o_err        = r_err;
  assign o_sram_csb   = ~w_issue;
  assign o_sram_wsb   = 1'b1;
  assign o_sram_raddr = w_issue ? w_issue_addr : r_raddr;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = S_FETCH;
      S_FETCH: if (r_issued == r_count) w_state_nxt = S_DRAIN;
      S_DRAIN: if (w_last_pop) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_base     <= '0;
      r_raddr    <= '0;
      r_count    <= '0;
      r_issued   <= '0;
      r_popped   <= '0;
      r_inflight <= 1'b0;
      r_fifo[0]  <= '0;
      r_fifo[1]  <= '0;
      r_rd_ptr   <= 1'b0;
      r_wr_ptr   <= 1'b0;
      r_occ      <= 2'd0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_done <= ((r_state == S_IDLE) && i_start && !w_req_err && w_req_zero) || w_last_pop;
      r_err  <= (r_state == S_IDLE) && i_start && w_req_err;

      if (w_accept) begin
        r_base   <= i_base_addr;
        r_count  <= {1'b0, i_num_words};
        r_issued <= '0;
        r_popped <= '0;
      end else begin
        if (w_issue) begin
          r_issued <= r_issued + CW'(1);
          r_raddr  <= w_issue_addr;
        end
        if (w_pop) begin
          r_popped <= w_popped_nxt;
        end
      end

      r_inflight <= w_issue;

      if (r_inflight) begin
        r_fifo[r_wr_ptr] <= i_sram_rdata;
        r_wr_ptr         <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end

      case ({r_inflight, w_pop})
        2'b10:   r_occ <= r_occ + 2'd1;
        2'b01:   r_occ <= r_occ - 2'd1;
        default: r_occ <= r_occ;
      endcase
    end
  end

endmodule

// File: tb/tb_weight_fetch_ctrl.sv
// tb/tb_weight_fetch_ctrl.sv - directed self-checking bench for weight_fetch_ctrl

module tb_weight_fetch_ctrl;

  logic        clk;
  logic        rst;
  logic        start;
  logic [14:0] base_addr;
  logic [14:0] num_words;
  logic        busy;
  logic        done;
  logic        err;
  logic        sram_csb;
  logic        sram_wsb;
  logic [14:0] sram_raddr;
  logic [79:0] sram_rdata;
  logic        w_valid;
  logic        w_ready;
  logic [79:0] w_data;

  int checks = 0;
  int errors = 0;

  weight_fetch_ctrl dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_start     (start),
    .i_base_addr (base_addr),
    .i_num_words (num_words),
    .o_busy      (busy),
    .o_done      (done),
    .o_err       (err),
    .o_sram_csb  (sram_csb),
    .o_sram_wsb  (sram_wsb),
    .o_sram_raddr(sram_raddr),
    .i_sram_rdata(sram_rdata),
    .o_w_valid   (w_valid),
    .i_w_ready   (w_ready),
    .o_w_data    (w_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [79:0] mem_word(input logic [14:0] a);
    logic [14:0] b;
    b = a + 15'd1;
    return {a, ~a, b, a ^ 15'h2AAA, a, 5'h15};
  endfunction

  always @(posedge clk) begin
    if (!sram_csb) sram_rdata <= mem_word(sram_raddr);
  end

  int          cyc = 0;
  logic [14:0] iss_q[$];
  int          iss_cyc_q[$];
  logic [79:0] got_q[$];
  int          done_n, err_n, done_cyc, busy_seen, occ_bad, stab_bad;
  logic        prev_stall;
  logic [79:0] prev_data;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (!rst) begin
      if (!sram_csb) begin
        iss_q.push_back(sram_raddr);
        iss_cyc_q.push_back(cyc);
      end
      if (w_valid && w_ready) got_q.push_back(w_data);
      if (done) begin
        done_n++;
        done_cyc = cyc;
      end
      if (err) err_n++;
      if (busy) busy_seen = 1;
      if (dut.r_occ > 2'd2) occ_bad++;
      if (prev_stall && (!w_valid || w_data !== prev_data)) stab_bad++;
      prev_stall = w_valid && !w_ready;
      prev_data  = w_data;
    end
  end

  task automatic clear_mon();
    iss_q.delete();
    iss_cyc_q.delete();
    got_q.delete();
    done_n = 0; err_n = 0; done_cyc = 0; busy_seen = 0;
    occ_bad = 0; stab_bad = 0; prev_stall = 1'b0; prev_data = '0;
  endtask

  task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic do_start(input logic [14:0] b, input logic [14:0] n);
    @(posedge clk); #1;
    start = 1'b1; base_addr = b; num_words = n;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (done_n == 0 && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    repeat (3) @(posedge clk);
    #1;
    check("done_pulse_count", 80'(done_n), 80'd1);
  endtask

  task automatic check_job(input logic [14:0] b, input int n);
    check("issue_count", 80'(iss_q.size()), 80'(n));
    check("word_count", 80'(got_q.size()), 80'(n));
    for (int i = 0; i < n; i++) begin
      if (i < iss_q.size()) check("issue_addr", 80'(iss_q[i]), 80'(b + 15'(i)));
      if (i < got_q.size()) check("word_data", got_q[i], mem_word(b + 15'(i)));
    end
  endtask

  logic [15:0] rpat;

  initial begin
    rst = 1'b1; start = 1'b0; base_addr = '0; num_words = '0; w_ready = 1'b0;
    clear_mon();
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 80'(busy), 80'd0);
    check("rst_done", 80'(done), 80'd0);
    check("rst_err", 80'(err), 80'd0);
    check("rst_csb", 80'(sram_csb), 80'd1);
    check("rst_wsb", 80'(sram_wsb), 80'd1);
    check("rst_raddr", 80'(sram_raddr), 80'd0);
    check("rst_valid", 80'(w_valid), 80'd0);
    check("rst_wdata", w_data, 80'd0);
    rst = 1'b0;

    // 1: full-rate job
    clear_mon(); w_ready = 1'b1;
    do_start(15'd0, 15'd5);
    wait_done(40);
    check_job(15'd0, 5);
    if (iss_cyc_q.size() == 5) check("t1_issue_span", 80'(iss_cyc_q[4] - iss_cyc_q[0]), 80'd4);
    if (iss_cyc_q.size() > 0) check("t1_latency", 80'(done_cyc - iss_cyc_q[0]), 80'd7);
    check("t1_idle_after", 80'(busy), 80'd0);

    // 2: pseudo-random back-pressure
    clear_mon(); rpat = 16'b1011_0010_1101_0110; w_ready = 1'b1;
    do_start(15'd100, 15'd8);
    for (int n = 0; n < 200 && done_n == 0; n++) begin
      w_ready = rpat[n % 16];
      @(posedge clk); #1;
    end
    w_ready = 1'b1;
    wait_done(40);
    check_job(15'd100, 8);
    check("t2_stall_stable", 80'(stab_bad), 80'd0);
    check("t2_occ_le2", 80'(occ_bad), 80'd0);

    // 3: consumer stalled from the start
    clear_mon(); w_ready = 1'b0;
    do_start(15'd300, 15'd4);
    repeat (10) @(posedge clk);
    #1;
    check("t3_stalled_issues", 80'(iss_q.size()), 80'd2);
    check("t3_csb_idle", 80'(sram_csb), 80'd1);
    w_ready = 1'b1;
    wait_done(40);
    check_job(15'd300, 4);

    // 4: address boundaries and empty job
    clear_mon();
    do_start(15'd20249, 15'd1);
    wait_done(40);
    check_job(15'd20249, 1);
    clear_mon();
    do_start(15'd20249, 15'd2);
    repeat (4) @(posedge clk);
    #1;
    check("t4_err_pulse", 80'(err_n), 80'd1);
    check("t4_err_no_issue", 80'(iss_q.size()), 80'd0);
    check("t4_err_no_busy", 80'(busy_seen), 80'd0);
    check("t4_err_no_done", 80'(done_n), 80'd0);
    clear_mon();
    do_start(15'd5, 15'd0);
    wait_done(10);
    check("t4_zero_no_busy", 80'(busy_seen), 80'd0);
    check("t4_zero_no_issue", 80'(iss_q.size()), 80'd0);
    check("t4_zero_no_err", 80'(err_n), 80'd0);

    // 5: asynchronous reset mid-job, then a fresh job
    clear_mon();
    do_start(15'd0, 15'd10);
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("t5_busy", 80'(busy), 80'd0);
    check("t5_csb", 80'(sram_csb), 80'd1);
    check("t5_raddr", 80'(sram_raddr), 80'd0);
    check("t5_valid", 80'(w_valid), 80'd0);
    check("t5_wdata", w_data, 80'd0);
    check("t5_done", 80'(done), 80'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    clear_mon();
    do_start(15'd0, 15'd2);
    wait_done(40);
    check_job(15'd0, 2);

    // 6: start during FETCH is ignored
    clear_mon();
    do_start(15'd500, 15'd6);
    start = 1'b1; base_addr = 15'd900; num_words = 15'd3;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(40);
    check_job(15'd500, 6);
    check("t6_no_err", 80'(err_n), 80'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
